// File: rtl/calendar_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : calendar_ctrl
// Purpose  : Day / month / year sequencer for the century clock. Advances the
//            date on the day-carry from the hour counter and offers a
//            button-driven set mode (day -> month -> year) for editing.
//            Optional century counter enabled by defining CAL_CENTURY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module calendar_ctrl #(
   parameter int YEAR_MAX = 99,
   parameter int RST_YEAR = 0
) (
   input  logic       clk_1Hz,
   input  logic       rst,
   input  logic       inc_day,
   input  logic       btn_mode,
   input  logic       btn_up,
   output logic [5:0] out_day,
   output logic [5:0] out_mon,
   output logic [6:0] out_year,
   output logic [1:0] set_sel
`ifdef CAL_CENTURY_EN
   ,
   output logic [6:0] out_cent
`endif
);

   // State encoding doubles as the display blink select.
   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_SET_DAY  = 2'd1,
      ST_SET_MON  = 2'd2,
      ST_SET_YEAR = 2'd3
   } state_t;

   localparam logic [6:0] c_year_max = 7'(YEAR_MAX);
   localparam logic [6:0] c_rst_year = 7'(RST_YEAR);
   localparam logic [6:0] c_cent_max = 7'd99;

   state_t     state_q, state_d;
   logic [5:0] day_q,   day_d;
   logic [5:0] mon_q,   mon_d;
   logic [6:0] year_q,  year_d;
`ifdef CAL_CENTURY_EN
   logic [6:0] cent_q,  cent_d;
`endif

   logic       year0_leap;   // leap status of year 0 (century-dependent)
   logic [5:0] mlen;         // length of the current month
   logic [5:0] mlen_new;     // length of the month after an edit
   logic [5:0] mon_inc;      // month + 1 with 12 -> 1 wrap
   logic [6:0] year_inc;     // year + 1 with YEAR_MAX -> 0 wrap

   // Days in a month; year 0 leap status is supplied by the caller so the
   // century rule stays outside this helper.
   function automatic logic [5:0] month_len(input logic [5:0] mon,
                                            input logic [6:0] year,
                                            input logic       leap_at_0);
      logic leap;
      leap = (year == 7'd0) ? leap_at_0 : (year[1:0] == 2'b00);
      case (mon)
         6'd4, 6'd6, 6'd9, 6'd11: month_len = 6'd30;
         6'd2:                    month_len = leap ? 6'd29 : 6'd28;
         default:                 month_len = 6'd31;
      endcase
   endfunction

   // Year 0 is a century year: Gregorian rule when centuries are tracked,
   // otherwise it behaves like any other multiple of four.
`ifdef CAL_CENTURY_EN
   assign year0_leap = (cent_q[1:0] == 2'b00);
`else
   assign year0_leap = 1'b1;
`endif

   // Current month length and the wrapped increments of month and year.
   always_comb begin
      mlen     = month_len(mon_q, year_q, year0_leap);
      mon_inc  = (mon_q >= 6'd12) ? 6'd1 : mon_q + 6'd1;
      year_inc = (year_q >= c_year_max) ? 7'd0 : year_q + 7'd1;
   end

   // Next-state logic: btn_mode beats btn_up beats inc_day; losers are dropped.
   always_comb begin
      state_d  = state_q;
      day_d    = day_q;
      mon_d    = mon_q;
      year_d   = year_q;
      mlen_new = mlen;
`ifdef CAL_CENTURY_EN
      cent_d   = cent_q;
`endif
      if (btn_mode) begin
         case (state_q)
            ST_RUN:      state_d = ST_SET_DAY;
            ST_SET_DAY:  state_d = ST_SET_MON;
            ST_SET_MON:  state_d = ST_SET_YEAR;
            default:     state_d = ST_RUN;
         endcase
      end else begin
         case (state_q)
            ST_RUN: begin
               // btn_up has no field to edit in RUN, so it does not block the
               // day carry.
               if (inc_day) begin
                  if (day_q >= mlen) begin
                     day_d = 6'd1;
                     mon_d = mon_inc;
                     if (mon_q >= 6'd12) begin
                        year_d = year_inc;
`ifdef CAL_CENTURY_EN
                        if (year_q >= c_year_max) begin
                           cent_d = (cent_q >= c_cent_max) ? 7'd0 : cent_q + 7'd1;
                        end
`endif
                     end
                  end else begin
                     day_d = day_q + 6'd1;
                  end
               end
            end
            ST_SET_DAY: begin
               if (btn_up) begin
                  day_d = (day_q >= mlen) ? 6'd1 : day_q + 6'd1;
               end
            end
            ST_SET_MON: begin
               if (btn_up) begin
                  mon_d    = mon_inc;
                  mlen_new = month_len(mon_inc, year_q, year0_leap);
                  if (day_q > mlen_new) begin
                     day_d = mlen_new;
                  end
               end
            end
            ST_SET_YEAR: begin
               // Editing the year never moves the century.
               if (btn_up) begin
                  year_d   = year_inc;
                  mlen_new = month_len(mon_q, year_inc, year0_leap);
                  if (day_q > mlen_new) begin
                     day_d = mlen_new;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Date and mode registers with synchronous reset.
   always_ff @(posedge clk_1Hz) begin
      if (rst) begin
         state_q <= ST_RUN;
         day_q   <= 6'd1;
         mon_q   <= 6'd1;
         year_q  <= c_rst_year;
`ifdef CAL_CENTURY_EN
         cent_q  <= 7'd0;
`endif
      end else begin
         state_q <= state_d;
         day_q   <= day_d;
         mon_q   <= mon_d;
         year_q  <= year_d;
`ifdef CAL_CENTURY_EN
         cent_q  <= cent_d;
`endif
      end
   end

   assign out_day  = day_q;
   assign out_mon  = mon_q;
   assign out_year = year_q;
   assign set_sel  = state_q;
`ifdef CAL_CENTURY_EN
   assign out_cent = cent_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_calendar_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_calendar_ctrl
// Purpose  : Self-checking bench for calendar_ctrl: fixed vector table,
//            directed date corner cases and randomized traffic compared
//            against a calendar-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calendar_ctrl;

   localparam int YEAR_MAX = 99;
   localparam int RST_YEAR = 0;

   logic       clk_1Hz = 1'b0;
   logic       rst = 1'b0;
   logic       inc_day = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_up = 1'b0;
   logic [5:0] out_day;
   logic [5:0] out_mon;
   logic [6:0] out_year;
   logic [1:0] set_sel;
`ifdef CAL_CENTURY_EN
   logic [6:0] out_cent;
`endif

   calendar_ctrl #(.YEAR_MAX(YEAR_MAX), .RST_YEAR(RST_YEAR)) dut (
      .clk_1Hz  (clk_1Hz),
      .rst      (rst),
      .inc_day  (inc_day),
      .btn_mode (btn_mode),
      .btn_up   (btn_up),
      .out_day  (out_day),
      .out_mon  (out_mon),
      .out_year (out_year),
      .set_sel  (set_sel)
`ifdef CAL_CENTURY_EN
      ,
      .out_cent (out_cent)
`endif
   );

   always #5 clk_1Hz = ~clk_1Hz;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: plain calendar arithmetic on integers.
   int md, mm, my, ms, mc;
   int days_tab [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

   function automatic bit leap(int yr);
`ifdef CAL_CENTURY_EN
      if (yr == 0) return (mc % 4) == 0;
`endif
      return (yr % 4) == 0;
   endfunction

   function automatic int dim(int mon, int yr);
      if (mon == 2 && leap(yr)) return 29;
      return days_tab[mon - 1];
   endfunction

   function automatic void model_step(bit r, bit m, bit u, bit i);
      if (r) begin
         md = 1; mm = 1; my = RST_YEAR; ms = 0; mc = 0;
      end else if (m) begin
         ms = (ms + 1) % 4;
      end else if (u && ms == 1) begin
         md = md + 1;
         if (md > dim(mm, my)) md = 1;
      end else if (u && ms == 2) begin
         mm = (mm % 12) + 1;
         if (md > dim(mm, my)) md = dim(mm, my);
      end else if (u && ms == 3) begin
         my = (my + 1) % (YEAR_MAX + 1);
         if (md > dim(mm, my)) md = dim(mm, my);
      end else if (i && ms == 0) begin
         md = md + 1;
         if (md > dim(mm, my)) begin
            md = 1;
            mm = mm + 1;
            if (mm > 12) begin
               mm = 1;
               my = my + 1;
               if (my > YEAR_MAX) begin
                  my = 0;
                  mc = (mc + 1) % 100;
               end
            end
         end
      end
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_date(input string name, input int d, input int m, input int y,
                              input int s);
      chk({name, ".day"},  int'(out_day),  d);
      chk({name, ".mon"},  int'(out_mon),  m);
      chk({name, ".year"}, int'(out_year), y);
      chk({name, ".sel"},  int'(set_sel),  s);
   endtask

   // One clock: drive pulses, let the edge happen, advance the model, compare.
   task automatic cycle(input bit r, input bit m, input bit u, input bit i);
      rst = r; btn_mode = m; btn_up = u; inc_day = i;
      @(posedge clk_1Hz);
      #1;
      rst = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; inc_day = 1'b0;
      model_step(r, m, u, i);
      expect_date("model", md, mm, my, ms);
`ifdef CAL_CENTURY_EN
      chk("model.cent", int'(out_cent), mc);
`endif
   endtask

   // Reach day/month/year through the set-mode UI, ending in RUN.
   task automatic set_date(input int d, input int m, input int y);
      cycle(1, 0, 0, 0);
      cycle(0, 1, 0, 0);
      cycle(0, 1, 0, 0);
      repeat (m - 1) cycle(0, 0, 1, 0);
      cycle(0, 1, 0, 0);
      repeat (y) cycle(0, 0, 1, 0);
      cycle(0, 1, 0, 0);
      cycle(0, 1, 0, 0);
      repeat (d - 1) cycle(0, 0, 1, 0);
      cycle(0, 1, 0, 0);
      cycle(0, 1, 0, 0);
      cycle(0, 1, 0, 0);
   endtask

   typedef struct {
      bit r, m, u, i;
      int d, mo, y, s;
   } vec_t;

   vec_t tbl [11];

   initial begin
      bit r, m, u, i;

      tbl[0]  = '{1, 0, 0, 0, 1, 1, 0, 0};  // reset
      tbl[1]  = '{0, 1, 1, 0, 1, 1, 0, 1};  // mode+up in RUN: state only
      tbl[2]  = '{0, 0, 1, 1, 2, 1, 0, 1};  // up+inc in SET_DAY: +1 once
      tbl[3]  = '{0, 0, 0, 1, 2, 1, 0, 1};  // inc ignored in SET_DAY
      tbl[4]  = '{0, 1, 0, 0, 2, 1, 0, 2};
      tbl[5]  = '{0, 0, 1, 0, 2, 2, 0, 2};
      tbl[6]  = '{0, 1, 0, 0, 2, 2, 0, 3};
      tbl[7]  = '{0, 0, 1, 0, 2, 2, 1, 3};
      tbl[8]  = '{0, 1, 0, 0, 2, 2, 1, 0};
      tbl[9]  = '{0, 0, 0, 1, 3, 2, 1, 0};
      tbl[10] = '{1, 0, 0, 0, 1, 1, 0, 0};  // reset again

      for (int k = 0; k < 11; k++) begin
         cycle(tbl[k].r, tbl[k].m, tbl[k].u, tbl[k].i);
         expect_date($sformatf("tbl%0d", k), tbl[k].d, tbl[k].mo, tbl[k].y, tbl[k].s);
      end

      // Non-leap February and a 30-day month.
      set_date(28, 2, 1);
      cycle(0, 0, 0, 1); expect_date("feb_nonleap", 1, 3, 1, 0);
      set_date(30, 4, 1);
      cycle(0, 0, 0, 1); expect_date("apr_end", 1, 5, 1, 0);

      // Leap February.
      set_date(28, 2, 4);
      cycle(0, 0, 0, 1); expect_date("leap_29", 29, 2, 4, 0);
      cycle(0, 0, 0, 1); expect_date("leap_mar", 1, 3, 4, 0);

      // Year 0 in the first century is leap under both configurations.
      set_date(28, 2, 0);
      cycle(0, 0, 0, 1); expect_date("year0_leap", 29, 2, 0, 0);

      // Year rollover.
      set_date(31, 12, 99);
      cycle(0, 0, 0, 1); expect_date("year_wrap", 1, 1, 0, 0);
`ifdef CAL_CENTURY_EN
      chk("year_wrap.cent", int'(out_cent), 1);
`endif

      // Clamp on month edit.
      set_date(31, 1, 1);
      cycle(0, 1, 0, 0);
      cycle(0, 1, 0, 0);
      cycle(0, 0, 1, 0); expect_date("clamp_mon", 28, 2, 1, 2);

      // Clamp on year edit.
      set_date(29, 2, 4);
      cycle(0, 1, 0, 0);
      cycle(0, 1, 0, 0);
      cycle(0, 1, 0, 0);
      cycle(0, 0, 1, 0); expect_date("clamp_year", 28, 2, 5, 3);

      // Set-day suppression and wrap.
      set_date(31, 1, 0);
      cycle(0, 1, 0, 0);
      cycle(0, 0, 0, 1); expect_date("setday_inc", 31, 1, 0, 1);
      cycle(0, 0, 1, 0); expect_date("setday_wrap", 1, 1, 0, 1);

      // Reset in the middle of an edit.
      cycle(0, 1, 0, 0);
      cycle(0, 0, 1, 0);
      cycle(1, 0, 0, 0); expect_date("reset_mid_edit", 1, 1, 0, 0);

      // Randomized traffic against the model.
      for (int n = 0; n < 4000; n++) begin
         r = ($urandom_range(0, 299) == 0);
         m = ($urandom_range(0, 7) == 0);
         u = ($urandom_range(0, 2) == 0);
         i = ($urandom_range(0, 1) == 0);
         if (ms == 0 && u && i) u = 1'b0;
         cycle(r, m, u, i);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/calendar_ctrl.md
# calendar_ctrl

Date sequencer for the century clock: holds day, month and year registers and advances them on the day-carry from the hour counter. A button-driven set-mode state machine lets the user edit each field. Month length (28/29/30/31) is derived internally from the current month and year. It sits between the hour counter and the display/BCD formatting stage.

## Interface

Parameters:
- `YEAR_MAX`, default 99: last year value; the year wraps from YEAR_MAX to 0.
- `RST_YEAR`, default 0: year loaded on reset.

Ports:
- `clk_1Hz` input 1: single clock; everything is registered on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `inc_day` input 1: one-cycle pulse from the hour counter on the 23→0 rollover.
- `btn_mode` input 1: one-cycle, debounced pulse that steps the set-mode FSM.
- `btn_up` input 1: one-cycle, debounced pulse that increments the selected field.
- `out_day` output 6: day, 1..31.
- `out_mon` output 6: month, 1..12.
- `out_year` output 7: year, 0..YEAR_MAX.
- `set_sel` output 2: 0 = run, 1 = day, 2 = month, 3 = year. Display blink select.
- `out_cent` output 7: century count. Present only with `CAL_CENTURY_EN`.

## Operation

FSM states are RUN, SET_DAY, SET_MON and SET_YEAR. `set_sel` equals the state encoding (0..3).

State transitions on `btn_mode`: RUN→SET_DAY→SET_MON→SET_YEAR→RUN.

Month length `mlen`:
- 31 for months 1, 3, 5, 7, 8, 10, 12.
- 30 for months 4, 6, 9, 11.
- Month 2: 29 if leap, else 28.
- Leap rule: `year[1:0]==0` (see Configuration for the year-0 exception).

RUN:
- `inc_day` with `out_day < mlen`: day+1.
- `inc_day` with `out_day == mlen`: day←1 and month+1.
- From month 12: month←1 and year+1.
- Year wraps YEAR_MAX→0.

SET_DAY:
- `btn_up`: day+1.
- Wraps mlen→1; month and year are unaffected.

SET_MON:
- `btn_up`: month+1, wrapping 12→1; year unaffected.
- If `out_day` exceeds the new month's length, day is clamped to that length on the same edge.

SET_YEAR:
- `btn_up`: year+1, wrapping YEAR_MAX→0.
- Same day clamp applies, e.g. Feb 29 → Feb 28 when the new year is not leap.

General rules:
- `inc_day` is ignored in every SET_* state. The pulse is dropped, not queued.
- Priority within one cycle: `rst` > `btn_mode` > `btn_up` > `inc_day`. A lower-priority event that loses in that cycle is discarded.
- All arithmetic is unsigned. No field ever holds an illegal value (day 0, month 0 or 13, year > YEAR_MAX) at any clock edge.

## Timing

- Reset (`rst` sampled high): day=1, mon=1, year=RST_YEAR, state=RUN, `set_sel`=0, `out_cent`=0.
- A reset asserted mid-edit returns to RUN and discards the edit.
- Every output is a register and changes one edge after the sampled event, i.e. latency 1 cycle.
- `mlen` is combinational from the current registers. The clamp uses the length of the new month/year, computed from the next-state values within the same cycle.
- Back-to-back pulses on consecutive cycles are each honoured: `inc_day` at most once per cycle, `btn_up` once per cycle.
- `btn_mode` and `btn_up` in the same cycle: the state advances and the field does not change.

## Configuration

- `CAL_CENTURY_EN` defined:
  - `out_cent` port and a 7-bit century register are present.
  - Year wrap YEAR_MAX→0 in RUN increments `out_cent`, wrapping 99→0. The SET_YEAR wrap does not touch the century.
  - Leap rule for year 0 becomes `out_cent[1:0]==0` (Gregorian century rule). All other years use `year[1:0]==0`.
- `CAL_CENTURY_EN` undefined:
  - No `out_cent` port.
  - Year 0 is treated as leap, like every year divisible by 4.

## Test plan

- Reset: assert `rst` for 1 cycle with arbitrary prior state → day=1, mon=1, year=0, `set_sel`=0 on the next edge.
- Non-leap February: date 28/2/year 1, one `inc_day` → 1/3/1. At 30/4/1, `inc_day` → 1/5/1.
- Leap and year rollover: 28/2/4 with `inc_day` → 29/2/4, then `inc_day` → 1/3/4. At 31/12/99, `inc_day` → 1/1/0; with `CAL_CENTURY_EN`, `out_cent` goes 0→1.
- Clamping: at 31/1/1, `btn_mode`×2 then `btn_up` → 28/2/1, `set_sel`=2. At 29/2/4 in SET_YEAR, `btn_up` → 29/2/5 becomes 28/2/5.
- Set-mode suppression: in SET_DAY, pulse `inc_day` → no change. `btn_up` at day 31 in January → day 1, month still 1.
- Simultaneous events: `btn_mode`+`btn_up` in RUN → state SET_DAY, day unchanged. `btn_up`+`inc_day` in SET_DAY → day+1 exactly once.
